ucie_ctl_fsm_adapter_rdi: RTL and testbench

Adapter-side (LP) RDI controller: the initiator counterpart of `UCIE_ctl_fsm_phy_top`. It sequences `lp_state_req` through bring-up, retrain, link reset and link error. It watches `pl_state_sts` with a per-request timeout. It owns the LP→PL mainband transmit handshake (`lp_valid`/`lp_irdy`/`pl_trdy`) through a one-entry hold register. It sits between the D2D adapter core and the PHY RDI.

---
 rtl/ucie_ctl_fsm_adapter_rdi_if.sv | 24 ++
 rtl/ucie_ctl_fsm_adapter_rdi.sv | 188 ++++++++++++++++++
 tb/tb_ucie_ctl_fsm_adapter_rdi.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucie_ctl_fsm_adapter_rdi_if.sv
// RDI signal bundle between the adapter-side (LP) controller and the PHY (PL).
// master = adapter/LP side, slave = PHY/PL side.
interface ucie_ctl_fsm_adapter_rdi_if #(
  parameter int NBYTES = 32
);
  logic [3:0]          lp_state_req;
  logic                lp_linkerror;
  logic                lp_irdy;
  logic                lp_valid;
  logic [NBYTES*8-1:0] lp_data;
  logic [3:0]          pl_state_sts;
  logic                pl_inband_pres;
  logic                pl_trdy;

  modport master (
    output lp_state_req, lp_linkerror, lp_irdy, lp_valid, lp_data,
    input  pl_state_sts, pl_inband_pres, pl_trdy
  );

  modport slave (
    input  lp_state_req, lp_linkerror, lp_irdy, lp_valid, lp_data,
    output pl_state_sts, pl_inband_pres, pl_trdy
  );
endinterface

// File: rtl/ucie_ctl_fsm_adapter_rdi.sv
// Adapter-side RDI controller: sequences lp_state_req against pl_state_sts with a
// per-request timeout, and owns the LP->PL transmit beat through a one-entry hold register.
module ucie_ctl_fsm_adapter_rdi #(
  parameter int NBYTES     = 32,
  parameter int NOP_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_link_enable,
  input  logic                i_req_retrain,
  input  logic                i_req_linkreset,
  input  logic                i_adapter_linkerror,
  input  logic                i_tx_valid,
  input  logic [NBYTES*8-1:0] i_tx_data,
  output logic                o_tx_ready,
  output logic                o_tx_drop,
  output logic                o_link_up,
  output logic                o_timeout,
  ucie_ctl_fsm_adapter_rdi_if.master rdi
);
  localparam logic [3:0] STS_RESET     = 4'b0000;
  localparam logic [3:0] STS_ACTIVE    = 4'b0001;
  localparam logic [3:0] STS_RETRAIN   = 4'b1011;
  localparam logic [3:0] STS_LINKRESET = 4'b1001;
  localparam logic [3:0] STS_LINKERROR = 4'b1010;
  localparam logic [3:0] STS_DISABLED  = 4'b1100;

  localparam int NW = $clog2(NOP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [NW-1:0] NOP_LOAD = NW'(NOP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET, S_NOP, S_REQ_ACTIVE, S_ACTIVE,
    S_REQ_RETRAIN, S_REQ_LINKRESET, S_LINKERROR, S_DISABLED
  } state_e;

  state_e              state_q, state_d;
  logic [NW-1:0]       nop_cnt_q, nop_cnt_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic                err_flag_q, err_flag_d;
  logic                err_seen_q, err_seen_d;
  logic                timeout_q, timeout_d;
  logic [3:0]          state_req_q;
  logic                link_up_q;
  logic                lp_valid_q, lp_valid_d;
  logic [NBYTES*8-1:0] lp_data_q, lp_data_d;
  logic                tx_drop_q, tx_drop_d;
  logic [3:0]          sts;
  logic                in_req, tx_accept, leaving_active;

  function automatic logic [3:0] req_enc(state_e s);
    case (s)
      S_REQ_ACTIVE, S_ACTIVE: return STS_ACTIVE;
      S_REQ_RETRAIN:          return STS_RETRAIN;
      S_REQ_LINKRESET:        return STS_LINKRESET;
      default:                return STS_RESET;
    endcase
  endfunction

  assign sts    = rdi.pl_state_sts;
  assign in_req = (state_q == S_REQ_ACTIVE) || (state_q == S_REQ_RETRAIN) ||
                  (state_q == S_REQ_LINKRESET);

  always_comb begin
    state_d    = state_q;
    err_flag_d = err_flag_q;
    err_seen_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_RESET:
        if (i_link_enable && (sts == STS_RESET) && rdi.pl_inband_pres) state_d = S_NOP;
      S_NOP:
        if (nop_cnt_q == '0) state_d = S_REQ_ACTIVE;
      S_REQ_ACTIVE:
        if (sts == STS_ACTIVE) state_d = S_ACTIVE;
        else if (to_cnt_q == TO_LAST) timeout_d = 1'b1;
      S_ACTIVE:
        if (i_adapter_linkerror) begin
          state_d    = S_LINKERROR;
          err_flag_d = 1'b1;
        end else if (i_req_linkreset) begin
          state_d = S_REQ_LINKRESET;
        end else if (i_req_retrain) begin
          state_d = S_REQ_RETRAIN;
        end else if ((sts == STS_RETRAIN) || (sts == STS_LINKRESET)) begin
          state_d = S_NOP;
        end
      S_REQ_RETRAIN:
        if (sts == STS_RETRAIN) state_d = S_NOP;
        else if (to_cnt_q == TO_LAST) timeout_d = 1'b1;
      S_REQ_LINKRESET:
        if (sts == STS_LINKRESET) state_d = S_NOP;
        else if (to_cnt_q == TO_LAST) timeout_d = 1'b1;
      S_LINKERROR: begin
        // The flag only drops after the PHY has acknowledged with LinkError status.
        err_seen_d = err_seen_q || (sts == STS_LINKERROR);
        if (i_adapter_linkerror) err_flag_d = 1'b1;
        else if (err_seen_d)     err_flag_d = 1'b0;
        if (!err_flag_d) state_d = S_NOP;
      end
      default: state_d = state_q;
    endcase

    if (timeout_d) begin
      state_d    = S_LINKERROR;
      err_flag_d = 1'b1;
    end

    if ((state_q != S_RESET) && (state_q != S_DISABLED)) begin
      if (sts == STS_DISABLED) begin
        state_d    = S_DISABLED;
        err_flag_d = 1'b0;
        timeout_d  = 1'b0;
      end else if (sts == STS_LINKERROR) begin
        state_d = S_LINKERROR;
      end
    end

    if (state_d != S_LINKERROR) err_seen_d = 1'b0;

    if ((state_d == S_NOP) && (state_q != S_NOP)) nop_cnt_d = NOP_LOAD;
    else if (state_q == S_NOP)                    nop_cnt_d = nop_cnt_q - 1'b1;
    else                                          nop_cnt_d = nop_cnt_q;

    to_cnt_d = (in_req && (state_d == state_q)) ? to_cnt_q + 1'b1 : '0;
  end

  assign o_tx_ready     = (state_q == S_ACTIVE) && (sts == STS_ACTIVE) &&
                          (!lp_valid_q || rdi.pl_trdy);
  assign tx_accept      = i_tx_valid && o_tx_ready;
  assign leaving_active = (state_q == S_ACTIVE) && (state_d != S_ACTIVE);

  always_comb begin
    lp_valid_d = lp_valid_q;
    lp_data_d  = lp_data_q;
    tx_drop_d  = 1'b0;
    if (tx_accept) begin
      lp_valid_d = 1'b1;
      lp_data_d  = i_tx_data;
    end else if (rdi.pl_trdy) begin
      lp_valid_d = 1'b0;
    end
    // A beat the PHY has not taken by the time we leave Active is discarded.
    if (leaving_active) begin
      tx_drop_d  = (lp_valid_q && !rdi.pl_trdy) || tx_accept;
      lp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_RESET;
      nop_cnt_q   <= '0;
      to_cnt_q    <= '0;
      err_flag_q  <= 1'b0;
      err_seen_q  <= 1'b0;
      timeout_q   <= 1'b0;
      state_req_q <= STS_RESET;
      link_up_q   <= 1'b0;
      lp_valid_q  <= 1'b0;
      lp_data_q   <= '0;
      tx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nop_cnt_q   <= nop_cnt_d;
      to_cnt_q    <= to_cnt_d;
      err_flag_q  <= err_flag_d;
      err_seen_q  <= err_seen_d;
      timeout_q   <= timeout_d;
      state_req_q <= req_enc(state_d);
      link_up_q   <= (state_d == S_ACTIVE) && (sts == STS_ACTIVE);
      lp_valid_q  <= lp_valid_d;
      lp_data_q   <= lp_data_d;
      tx_drop_q   <= tx_drop_d;
    end
  end

  assign rdi.lp_state_req = state_req_q;
  assign rdi.lp_linkerror = err_flag_q;
  assign rdi.lp_valid     = lp_valid_q;
  assign rdi.lp_data      = lp_data_q;
  assign rdi.lp_irdy      = lp_valid_q || (i_tx_valid && (state_q == S_ACTIVE));
  assign o_link_up        = link_up_q;
  assign o_timeout        = timeout_q;
  assign o_tx_drop        = tx_drop_q;
endmodule

// File: tb/tb_ucie_ctl_fsm_adapter_rdi.sv
// Self-checking bench for ucie_ctl_fsm_adapter_rdi: scripted PHY responses with random
// delays and random beats, checked against cycle expectations and a beat scoreboard.
module tb_ucie_ctl_fsm_adapter_rdi;
  localparam int NBYTES = 4;
  localparam int NOP    = 2;
  localparam int TMO    = 16;
  localparam int DW     = NBYTES * 8;
  localparam logic [3:0] ST_RESET = 4'b0000, ST_ACTIVE = 4'b0001, ST_RETRAIN = 4'b1011,
                         ST_LINKRESET = 4'b1001, ST_LINKERROR = 4'b1010, ST_DISABLED = 4'b1100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          link_en = 1'b0, req_rt = 1'b0, req_lr = 1'b0, a_err = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready, tx_drop, link_up, tmo;
  int            n_checks = 0;
  int            n_pass = 0;

  ucie_ctl_fsm_adapter_rdi_if #(.NBYTES(NBYTES)) rdi ();

  ucie_ctl_fsm_adapter_rdi #(.NBYTES(NBYTES), .NOP_CYCLES(NOP), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_link_enable(link_en), .i_req_retrain(req_rt),
    .i_req_linkreset(req_lr), .i_adapter_linkerror(a_err), .i_tx_valid(tx_valid),
    .i_tx_data(tx_data), .o_tx_ready(tx_ready), .o_tx_drop(tx_drop),
    .o_link_up(link_up), .o_timeout(tmo), .rdi(rdi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, " req"}, rdi.lp_state_req, ST_RESET);
    check_eq({tag, " linkerror"}, rdi.lp_linkerror, 0);
    check_eq({tag, " irdy"}, rdi.lp_irdy, 0);
    check_eq({tag, " valid"}, rdi.lp_valid, 0);
    check_eq({tag, " data"}, rdi.lp_data, 0);
    check_eq({tag, " ready"}, tx_ready, 0);
    check_eq({tag, " drop"}, tx_drop, 0);
    check_eq({tag, " link_up"}, link_up, 0);
    check_eq({tag, " timeout"}, tmo, 0);
  endtask

  // Caller has driven the inputs that move the DUT into NOP at the next edge.
  task automatic nop_to_active(input string tag, input int dly);
    $display("%s: NOP then Active, PHY delay %0d", tag, dly);
    for (int j = 1; j <= NOP + dly + 2; j++) begin
      next_cyc();
      if (j == NOP + 1 + dly) rdi.pl_state_sts = ST_ACTIVE;
      settle();
      check_eq({tag, " req"}, rdi.lp_state_req, (j >= NOP + 1) ? ST_ACTIVE : ST_RESET);
      check_eq({tag, " link_up"}, link_up, (j >= NOP + 2 + dly) ? 1 : 0);
      check_eq({tag, " timeout"}, tmo, 0);
      check_eq({tag, " linkerror"}, rdi.lp_linkerror, 0);
    end
  endtask

  // Caller has driven a local request; PHY acknowledges after dly cycles.
  task automatic req_and_ack(input string tag, input logic [3:0] exp_req, input int dly,
                             input logic first_drop);
    $display("%s: request 0x%0h, PHY ack delay %0d", tag, exp_req, dly);
    for (int j = 1; j <= dly + 1; j++) begin
      next_cyc();
      if (j == 1) begin
        req_rt = 1'b0;
        req_lr = 1'b0;
      end
      if (j == dly + 1) rdi.pl_state_sts = exp_req;
      settle();
      check_eq({tag, " req"}, rdi.lp_state_req, exp_req);
      check_eq({tag, " link_up"}, link_up, 0);
      check_eq({tag, " drop"}, tx_drop, (j == 1) ? first_drop : 1'b0);
      check_eq({tag, " valid"}, rdi.lp_valid, 0);
      check_eq({tag, " ready"}, tx_ready, 0);
    end
  endtask

  task automatic bring_up(input int dly);
    next_cyc();
    link_en = 1'b1;
    rdi.pl_inband_pres = 1'b1;
    rdi.pl_state_sts = ST_RESET;
    settle();
    check_eq("bringup cycle0 req", rdi.lp_state_req, ST_RESET);
    nop_to_active("bringup", dly);
  endtask

  task automatic stream(input int nbeats);
    logic [DW-1:0] q[$];
    logic [DW-1:0] beat;
    logic          trdy_bit;
    logic          exp_ready;
    int            sent, got, cyc;
    sent = 0; got = 0; cyc = 0; trdy_bit = 1'b1;
    beat = $urandom;
    while (got < nbeats && cyc < 400) begin
      next_cyc();
      rdi.pl_trdy = trdy_bit;
      tx_valid = (sent < nbeats) && ($urandom_range(0, 3) != 0);
      tx_data = tx_valid ? beat : DW'($urandom);
      settle();
      exp_ready = (q.size() == 0) || trdy_bit;
      check_eq("stream ready", tx_ready, exp_ready);
      check_eq("stream valid", rdi.lp_valid, (q.size() != 0) ? 1 : 0);
      check_eq("stream irdy", rdi.lp_irdy, ((q.size() != 0) || tx_valid) ? 1 : 0);
      if (q.size() != 0) begin
        check_eq("stream data", rdi.lp_data, q[0]);
        if (trdy_bit) begin
          $display("beat %0d delivered data=0x%08h", got, q[0]);
          void'(q.pop_front());
          got++;
        end
      end
      if (tx_valid && exp_ready) begin
        q.push_back(tx_data);
        sent++;
        beat = $urandom;
      end
      trdy_bit = !trdy_bit;
      cyc++;
    end
    check_eq("stream beats delivered", got, nbeats);
    next_cyc();
    tx_valid = 1'b0;
    rdi.pl_trdy = 1'b0;
    settle();
    check_eq("stream drained valid", rdi.lp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    rdi.pl_state_sts = ST_RESET;
    rdi.pl_inband_pres = 1'b0;
    rdi.pl_trdy = 1'b0;

    // Reset values
    repeat (2) settle();
    check_reset_vals("reset");
    rst = 1'b0;

    bring_up(3);
    stream(20);

    // Local retrain
    next_cyc(); req_rt = 1'b1; settle();
    check_eq("retrain pre req", rdi.lp_state_req, ST_ACTIVE);
    req_and_ack("retrain", ST_RETRAIN, $urandom_range(0, 8), 1'b0);
    nop_to_active("retrain reentry", $urandom_range(0, 8));

    // PHY-initiated retrain
    next_cyc(); rdi.pl_state_sts = ST_RETRAIN; settle();
    check_eq("phy retrain pre link_up", link_up, 1);
    nop_to_active("phy retrain", $urandom_range(0, 8));

    // LinkReset with a beat still held
    next_cyc(); tx_valid = 1'b1; tx_data = DW'($urandom); held = tx_data; rdi.pl_trdy = 1'b0;
    settle();
    check_eq("linkreset beat ready", tx_ready, 1);
    next_cyc(); tx_valid = 1'b0; req_lr = 1'b1; settle();
    check_eq("linkreset held valid", rdi.lp_valid, 1);
    check_eq("linkreset held data", rdi.lp_data, held);
    check_eq("linkreset pre drop", tx_drop, 0);
    req_and_ack("linkreset", ST_LINKRESET, $urandom_range(0, 8), 1'b1);
    nop_to_active("linkreset reentry", $urandom_range(0, 8));

    // Timeout in REQ_ACTIVE
    next_cyc(); rdi.pl_state_sts = ST_RETRAIN; settle();
    $display("timeout: REQ_ACTIVE never acknowledged");
    for (int j = 1; j <= NOP + TMO + 3; j++) begin
      next_cyc(); settle();
      check_eq("timeout req", rdi.lp_state_req,
               (j >= NOP + 1 && j < NOP + 1 + TMO) ? ST_ACTIVE : ST_RESET);
      check_eq("timeout pulse", tmo, (j == NOP + 1 + TMO) ? 1 : 0);
      check_eq("timeout linkerror", rdi.lp_linkerror, (j >= NOP + 1 + TMO) ? 1 : 0);
    end
    next_cyc(); rdi.pl_state_sts = ST_LINKERROR; settle();
    check_eq("timeout linkerror at 1010", rdi.lp_linkerror, 1);
    next_cyc(); settle();
    check_eq("timeout linkerror cleared", rdi.lp_linkerror, 0);
    check_eq("timeout lerr req", rdi.lp_state_req, ST_RESET);
    next_cyc(); rdi.pl_state_sts = ST_RESET; settle();
    nop_to_active("timeout recovery", $urandom_range(0, 8));

    // Adapter-detected link error
    next_cyc(); a_err = 1'b1; settle();
    check_eq("aerr pre linkerror", rdi.lp_linkerror, 0);
    next_cyc(); settle();
    check_eq("aerr req", rdi.lp_state_req, ST_RESET);
    check_eq("aerr linkerror", rdi.lp_linkerror, 1);
    check_eq("aerr link_up", link_up, 0);
    next_cyc(); a_err = 1'b0; settle();
    check_eq("aerr hold linkerror", rdi.lp_linkerror, 1);
    next_cyc(); settle();
    check_eq("aerr wait 1010 linkerror", rdi.lp_linkerror, 1);
    next_cyc(); rdi.pl_state_sts = ST_LINKERROR; settle();
    next_cyc(); settle();
    check_eq("aerr cleared linkerror", rdi.lp_linkerror, 0);
    next_cyc(); rdi.pl_state_sts = ST_RESET; settle();
    nop_to_active("aerr recovery", $urandom_range(0, 8));

    // PHY LinkError beats a simultaneous local retrain
    next_cyc(); rdi.pl_state_sts = ST_LINKERROR; req_rt = 1'b1; settle();
    next_cyc(); req_rt = 1'b0; settle();
    check_eq("override lerr req", rdi.lp_state_req, ST_RESET);
    check_eq("override lerr linkerror", rdi.lp_linkerror, 0);
    check_eq("override lerr link_up", link_up, 0);
    next_cyc(); rdi.pl_state_sts = ST_RESET; settle();
    nop_to_active("override recovery", $urandom_range(0, 8));

    // Asynchronous reset with a held beat: dropped silently
    next_cyc(); tx_valid = 1'b1; tx_data = DW'($urandom); rdi.pl_trdy = 1'b0; settle();
    next_cyc(); tx_valid = 1'b0; settle();
    check_eq("async pre valid", rdi.lp_valid, 1);
    #2; rst = 1'b1; link_en = 1'b0; rdi.pl_state_sts = ST_RESET;
    #1;
    check_reset_vals("async reset");
    settle();
    check_eq("async drop after", tx_drop, 0);
    rst = 1'b0;
    bring_up($urandom_range(0, 10));

    // Disabled is sticky until reset
    next_cyc(); rdi.pl_state_sts = ST_DISABLED; settle();
    $display("disabled: holding with varied PHY status");
    for (int j = 1; j <= 8; j++) begin
      next_cyc();
      rdi.pl_state_sts = (j % 2 == 1) ? ST_ACTIVE : ST_LINKERROR;
      req_rt = 1'($urandom_range(0, 1));
      settle();
      check_eq("disabled req", rdi.lp_state_req, ST_RESET);
      check_eq("disabled link_up", link_up, 0);
      check_eq("disabled linkerror", rdi.lp_linkerror, 0);
      check_eq("disabled ready", tx_ready, 0);
    end
    req_rt = 1'b0;
    #2; rst = 1'b1;
    #1;
    check_reset_vals("final reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
